// File: rtl/jtmx5k_snd_comm_if.sv
// Sound-command mailbox bus between the main CPU, the sound CPU and jtmx5k_snd_comm.
//   master : drives the command strobes (snd_irq, snd_latch, cpu_cen, latch_cs, ack_cs, RnW)
//            and observes dout, int_n, pending, overflow.
//   slave  : the mailbox block itself (opposite directions).
interface jtmx5k_snd_comm_if;
  logic       cpu_cen;    // sound-CPU clock enable
  logic       snd_irq;    // main-CPU sound request (level, edge-detected inside)
  logic [7:0] snd_latch;  // main-CPU command byte
  logic       latch_cs;   // sound-CPU read of the command latch
  logic       ack_cs;     // sound-CPU write to the IRQ-acknowledge address
  logic       RnW;        // sound-CPU read/not-write
  logic [7:0] dout;       // command byte at queue head
  logic       int_n;      // sound-CPU interrupt, active-low
  logic       pending;    // unread byte held
  logic       overflow;   // sticky: a byte was dropped

  modport master (
    output cpu_cen, snd_irq, snd_latch, latch_cs, ack_cs, RnW,
    input  dout, int_n, pending, overflow
  );

  modport slave (
    input  cpu_cen, snd_irq, snd_latch, latch_cs, ack_cs, RnW,
    output dout, int_n, pending, overflow
  );
endinterface

// File: rtl/jtmx5k_snd_comm.sv
// Main-CPU to sound-CPU command mailbox.
// A rising edge of snd_irq pushes snd_latch; a sound-CPU read of the latch pops the head
// (dout is valid during that read); an ack write clears the interrupt.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : jtmx5k_snd_comm_if.slave (strobes in; dout/int_n/pending/overflow out)
// Configuration macro JTMX5K_SNDCOMM_FIFO_EN: when defined the storage is a 4-entry FIFO,
// otherwise a single overwrite register.
module jtmx5k_snd_comm (
  input  logic             clk,
  input  logic             rst_n,
  jtmx5k_snd_comm_if.slave bus
);

`ifdef JTMX5K_SNDCOMM_FIFO_EN
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 3;
`else
  localparam int unsigned CntW  = 1;
`endif

  logic            irq_q;
  logic            push, pop, ack;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      head_q, head_d;
  logic            flag_q, flag_d;
  logic            repost_q, repost_d;
  logic            ovf_q, ovf_d;
  logic            pend_q;

  // Push is edge based so a long snd_irq pulse only enqueues once.
  assign push = bus.snd_irq && !irq_q;
  // Reads of an empty mailbox are harmless: no pop, head keeps its last value.
  assign pop  = bus.latch_cs && bus.RnW && bus.cpu_cen && (count_q != '0);
  assign ack  = bus.ack_cs && !bus.RnW && bus.cpu_cen;

`ifdef JTMX5K_SNDCOMM_FIFO_EN
  logic [7:0] mem_q [Depth];
  logic [7:0] mem_d [Depth];
  logic [1:0] rd_q, rd_d, wr_q, wr_d;
  logic       push_ok;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    ovf_d   = ovf_q;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push_ok = push && ((count_q != CntW'(Depth)) || pop);
    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_q] = bus.snd_latch;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    // Reading through mem_d covers a push landing on the new head slot.
    if (count_d != '0) head_d = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end
`else
  // Single register: the head itself is the storage; a new push always wins.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    ovf_d   = ovf_q;
    if (pop) count_d = 1'b0;
    if (push) begin
      head_d  = bus.snd_latch;
      count_d = 1'b1;
      if (count_q != '0) ovf_d = 1'b1;
    end
  end
`endif

  // Interrupt flag: push dominates, then ack/pop clear, then re-post after a partial drain.
  always_comb begin
    flag_d = flag_q;
    if (push) begin
      flag_d = 1'b1;
    end else if (ack || pop) begin
      flag_d = 1'b0;
    end else if (repost_q) begin
      flag_d = 1'b1;
    end
  end

  // A pop that leaves bytes behind re-raises the interrupt one clk later.
  assign repost_d = pop && !push && (count_d != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= 1'b0;
      count_q  <= '0;
      head_q   <= '0;
      flag_q   <= 1'b0;
      repost_q <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      irq_q    <= bus.snd_irq;
      count_q  <= count_d;
      head_q   <= head_d;
      flag_q   <= flag_d;
      repost_q <= repost_d;
      ovf_q    <= ovf_d;
      pend_q   <= (count_d != '0);
    end
  end

  assign bus.dout     = head_q;
  assign bus.int_n    = !flag_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_jtmx5k_snd_comm.sv
// Self-checking bench for jtmx5k_snd_comm: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_jtmx5k_snd_comm;

`ifdef JTMX5K_SNDCOMM_FIFO_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  jtmx5k_snd_comm_if bus ();

  jtmx5k_snd_comm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_head;
  bit         m_flag, m_repost, m_ovf, m_prev;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head   = 8'h00;
    m_flag   = 1'b0;
    m_repost = 1'b0;
    m_ovf    = 1'b0;
    m_prev   = 1'b0;
  endtask

  task automatic model_step(input bit irq, input logic [7:0] lat, input bit lcs, input bit acs,
                            input bit rnw, input bit cen);
    bit push, pop, ack;
    int n0;
    n0   = q.size();
    push = irq && !m_prev;
    pop  = lcs && rnw && cen && (n0 > 0);
    ack  = acs && !rnw && cen;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (Cap == 1) begin
        if (n0 != 0) m_ovf = 1'b1;
        q.delete();
        q.push_back(lat);
      end else if (q.size() < Cap) begin
        q.push_back(lat);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (q.size() > 0) m_head = q[0];
    if (push)             m_flag = 1'b1;
    else if (ack || pop)  m_flag = 1'b0;
    else if (m_repost)    m_flag = 1'b1;
    m_repost = pop && !push && (q.size() > 0);
    m_prev   = irq;
  endtask

  task automatic compare_model(input string tag);
    check_eq({tag, "_dout"}, bus.dout, m_head);
    check_eq({tag, "_int_n"}, {7'd0, bus.int_n}, {7'd0, !m_flag});
    check_eq({tag, "_pending"}, {7'd0, bus.pending}, {7'd0, q.size() != 0});
    check_eq({tag, "_overflow"}, {7'd0, bus.overflow}, {7'd0, m_ovf});
  endtask

  // Called at posedge+1; applies inputs for one full clock and checks after the edge.
  task automatic step(input bit irq, input logic [7:0] lat, input bit lcs, input bit acs,
                      input bit rnw, input bit cen);
    bus.snd_irq   = irq;
    bus.snd_latch = lat;
    bus.latch_cs  = lcs;
    bus.ack_cs    = acs;
    bus.RnW       = rnw;
    bus.cpu_cen   = cen;
    @(posedge clk);
    model_step(irq, lat, lcs, acs, rnw, cen);
    #1;
    compare_model("model");
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, b, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic pop_byte();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  // Reset state must appear without any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_int_n", {7'd0, bus.int_n}, 8'h01);
    check_eq("rst_pending", {7'd0, bus.pending}, 8'h00);
    check_eq("rst_dout", bus.dout, 8'h00);
    check_eq("rst_overflow", {7'd0, bus.overflow}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.snd_irq   = 1'b0;
    bus.snd_latch = 8'h00;
    bus.latch_cs  = 1'b0;
    bus.ack_cs    = 1'b0;
    bus.RnW       = 1'b1;
    bus.cpu_cen   = 1'b0;
    rst_n         = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Long snd_irq pulse yields exactly one push.
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("r29_dout", bus.dout, 8'h5A);
    check_eq("r29_pending", {7'd0, bus.pending}, 8'h01);
    check_eq("r29_int_n", {7'd0, bus.int_n}, 8'h00);
    repeat (9) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);

    // Ack drops int_n but keeps the byte.
    step(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("r30_int_n", {7'd0, bus.int_n}, 8'h01);
    check_eq("r30_pending", {7'd0, bus.pending}, 8'h01);
    check_eq("r30_dout", bus.dout, 8'h5A);

    // Ack without cpu_cen is ignored.
    push_byte(8'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("nocen_int_n", {7'd0, bus.int_n}, 8'h00);
    do_reset();

`ifdef JTMX5K_SNDCOMM_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(8'h11 * i);
      push_byte(b);
    end
    check_eq("r31_overflow", {7'd0, bus.overflow}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] e;
      e = 8'(8'h11 * i);
      check_eq("r31_read", bus.dout, e);
      pop_byte();
    end
    check_eq("r31_pending", {7'd0, bus.pending}, 8'h00);
    check_eq("r31_int_n", {7'd0, bus.int_n}, 8'h01);
    do_reset();

    push_byte(8'h10);
    check_eq("r32_read", bus.dout, 8'h10);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("r32_dout", bus.dout, 8'h77);
    check_eq("r32_pending", {7'd0, bus.pending}, 8'h01);
    check_eq("r32_int_n", {7'd0, bus.int_n}, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_byte();
    check_eq("r32_drained", {7'd0, bus.pending}, 8'h00);
    do_reset();
`else
    push_byte(8'hA1);
    push_byte(8'hB2);
    check_eq("r33_dout", bus.dout, 8'hB2);
    check_eq("r33_overflow", {7'd0, bus.overflow}, 8'h01);
    pop_byte();
    check_eq("r33_pending", {7'd0, bus.pending}, 8'h00);
    check_eq("r33_hold", bus.dout, 8'hB2);
    do_reset();
`endif

    // Three bytes queued, then an asynchronous reset (checked inside do_reset).
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    do_reset();

    // Randomized traffic, with a reset taken while snd_irq may be high.
    begin
      bit irq_r;
      irq_r = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 2) == 0) irq_r = !irq_r;
        step(irq_r, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             1'($urandom), $urandom_range(0, 3) != 0);
        if (n == 300) begin
          bus.snd_irq = 1'b1;
          irq_r       = 1'b1;
          do_reset();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtmx5k_snd_comm.md
JTMX5K_SND_COMM -- requirements
Module: jtmx5k_snd_comm

Interface
REQ-001 clk  input  1  system clock, 24 MHz.
REQ-002 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 cpu_cen  input  1  sound-CPU clock enable; all sound-CPU strobes are qualified by it.
REQ-004 snd_irq  input  1  main-CPU sound request; may stay high for several clk cycles.
REQ-005 snd_latch  input  8  main-CPU command byte, stable while snd_irq is high.
REQ-006 latch_cs  input  1  sound-CPU read of the command latch.
REQ-007 ack_cs  input  1  sound-CPU write to the IRQ-acknowledge address.
REQ-008 RnW  input  1  sound-CPU read/not-write.
REQ-009 dout  output  8  command byte at queue head; combinational from the head register.
REQ-010 int_n  output  1  sound-CPU interrupt, active-low, registered.
REQ-011 pending  output  1  high while at least one unread byte is held.
REQ-012 overflow  output  1  sticky flag: a byte was dropped.

Function
REQ-013 Push event is the clk-domain rising edge of snd_irq: exactly one push per low-to-high transition, independent of cpu_cen.
REQ-014 Push captures snd_latch from the same clk cycle the rising edge is detected.
REQ-015 Pop event is latch_cs && RnW && cpu_cen; it pops at the end of that cycle, so dout is valid with zero latency during the read.
REQ-016 Ack event is ack_cs && !RnW && cpu_cen.
REQ-017 Reading while empty returns the last head value, causes no pop and leaves the state unchanged.
REQ-018 The IRQ flag sets on a push; it clears on ack or pop; int_n is the registered inverse of the flag, one clk after the event.
REQ-019 After a pop that leaves data pending, the IRQ flag re-sets on the next clk.
REQ-020 If push and ack happen in the same cycle, push wins and the IRQ flag stays set.
REQ-021 If push and pop happen in the same cycle, both take effect: the popped byte is the old head and the pushed byte is enqueued.
REQ-022 pending equals (stored count != 0), registered.
REQ-023 The count never wraps; it saturates at capacity as defined in REQ-026/REQ-027.

Reset
REQ-024 While rst_n is low, the block is cleared asynchronously: count 0, head/storage 0, dout 0x00, int_n 1, pending 0, overflow 0, edge detector primed to snd_irq=0.
REQ-025 If reset is asserted mid-operation, all queued bytes are discarded; the first rising edge of snd_irq after release is a new push.

Configuration
REQ-026 With JTMX5K_SNDCOMM_FIFO_EN defined, storage is a 4-entry FIFO: 2-bit read/write pointers wrap modulo 4 and a 3-bit count runs 0..4. A push when the count is 4 and no simultaneous pop is dropped and sets overflow. A push when the count is 4 with a simultaneous pop is accepted.
REQ-027 Without JTMX5K_SNDCOMM_FIFO_EN, storage is a single register. A push overwrites it and sets pending. A push while already pending sets overflow, with the new value kept. On a push and pop in the same cycle, the push wins and pending stays 1.
REQ-028 overflow clears only on reset, in both configurations.

Verification
REQ-029 Reset release, snd_irq held high for 10 clk with snd_latch=0x5A -> exactly one push; dout=0x5A, pending=1, int_n=0 one clk after the edge.
REQ-030 Ack strobe with cpu_cen after REQ-029 -> int_n=1 next clk, pending stays 1, dout=0x5A.
REQ-031 FIFO_EN: push 0x11,0x22,0x33,0x44,0x55 with no reads -> overflow=1; four pops return 0x11..0x44, then pending=0 and int_n=1.
REQ-032 FIFO_EN: a pop coinciding with a push of 0x77 at count 1 (head 0x10) -> read returns 0x10, dout=0x77 next, count stays 1, int_n low.
REQ-033 No FIFO_EN: push 0xA1 then 0xB2 without a read -> dout=0xB2, overflow=1; one pop -> pending=0.
REQ-034 rst_n pulsed low while count=3 -> int_n=1, pending=0, dout=0x00 immediately, without waiting for a clk edge; overflow=0.
